// File: rtl/reg_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-bank write arbiter.
//   ST_IDLE / ST_WRITE : two-state FSM encoding (legacy 1-bit localparams)
//   clog2()            : ceiling log2, used for address, pointer and counter
//                        widths
// ---------------------------------------------------------------------------
package reg_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_WRITE = 1'b1;

  // Ceiling log2; clog2(1) returns 0, so callers that need a real bit
  // field clamp the result to at least one bit.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_register_ce.sv
// ---------------------------------------------------------------------------
// register_ce
// One N-bit storage word of the register bank.
//   q     : stored value
//   d     : value loaded when ce is high
//   ce    : clock enable
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears q to 0
// ---------------------------------------------------------------------------
module register_ce #(
  parameter int N = 8
) (
  output logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         ce,
  input  logic         clk,
  input  logic         reset
);

  // Reset has priority over the enable, so a word being written in the
  // same cycle that reset is sampled still comes up as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (ce) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// NREG x WIDTH register bank with one write port shared by NREQ requesters
// under round-robin arbitration, plus a combinational read port.
//   clk, reset : clock and synchronous active-high reset
//   req        : per-requester write request (level)
//   lock       : per-requester burst hold, honoured only while granted
//   wr_addr    : flattened addresses, requester i at [i*AW +: AW]
//   wr_data    : flattened data, requester i at [i*WIDTH +: WIDTH]
//   grant      : registered one-hot grant, zero when idle
//   busy       : high while a write cycle is in progress
//   rd_addr    : read address
//   rd_data    : bank[rd_addr], zero for addresses beyond the bank
// ---------------------------------------------------------------------------
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NREG      = 8,
  parameter int AW        = clog2(NREG),
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  localparam int PW = (NREQ > 1) ? clog2(NREQ) : 1;
  localparam int CW = (BURST_MAX > 1) ? clog2(BURST_MAX) : 1;

  logic              state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     win_q, win_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     burst_cnt_q, burst_cnt_d;

  logic              found;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     ptr_after_win;
  logic [AW-1:0]     addr_arr [NREQ];
  logic [WIDTH-1:0]  data_arr [NREQ];
  logic [AW-1:0]     sel_addr;
  logic [WIDTH-1:0]  sel_data;
  logic [NREG-1:0]   word_ce;
  logic [WIDTH-1:0]  bank [NREG];

  // Unpack the flattened request buses so the winner can be selected with
  // a plain array index.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = wr_addr[g*AW +: AW];
    assign data_arr[g] = wr_data[g*WIDTH +: WIDTH];
  end

  assign sel_addr = addr_arr[win_q];
  assign sel_data = data_arr[win_q];

  // Round-robin pick: walk the request vector starting at ptr and wrapping,
  // keeping the first requester found. This is the rotate + priority
  // encode folded into one loop.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[PW'((int'(ptr_q) + i) % NREQ)]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + i) % NREQ);
      end
    end
  end

  assign ptr_after_win = (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);

  // FSM next-state logic. IDLE launches a grant for the round-robin winner;
  // WRITE either extends a locked burst or drops back to IDLE and moves the
  // pointer past the requester just served, which is what keeps it fair.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    burst_cnt_d = burst_cnt_q;
    if (state_q == ST_IDLE) begin
      if (found) begin
        state_d     = ST_WRITE;
        grant_d     = NREQ'(1) << pick;
        win_d       = pick;
        burst_cnt_d = '0;
      end
    end else begin
      if (req[win_q] && lock[win_q] && (burst_cnt_q < CW'(BURST_MAX - 1))) begin
        burst_cnt_d = burst_cnt_q + CW'(1);
      end else begin
        state_d = ST_IDLE;
        grant_d = '0;
        ptr_d   = ptr_after_win;
      end
    end
  end

  // Arbiter state registers; reset can land mid-burst and simply abandons it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      win_q       <= '0;
      ptr_q       <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Register bank. An address past the last word matches no enable, so such
  // a grant cycle is consumed without changing anything.
  for (genvar j = 0; j < NREG; j++) begin : g_bank
    assign word_ce[j] = (state_q == ST_WRITE) && (sel_addr == AW'(j));
    register_ce #(.N(WIDTH)) u_word (
      .q     (bank[j]),
      .d     (sel_data),
      .ce    (word_ce[j]),
      .clk   (clk),
      .reset (reset)
    );
  end

  // Combinational read with no write bypass; unmatched addresses read 0.
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < NREG; j++) begin
      if (rd_addr == AW'(j)) begin
        rd_data = bank[j];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_WRITE);

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Register bank of NREG words of WIDTH bits with a single write port shared by NREQ requesters under round-robin arbitration, plus a combinational read port. It sits between the lab datapath units (ALU result, load path, immediate path, debug) and the CPU register storage. It sequences every write so that exactly one requester updates the bank per grant cycle.

## Interface
- WIDTH, 8, data width of each register
- NREG, 8, number of registers in the bank
- AW, 3, address width; AW = clog2(NREG)
- NREQ, 4, number of write requesters
- BURST_MAX, 4, maximum consecutive grant cycles one requester may hold via lock (≥1)
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester write request, level
- lock  in  NREQ  per-requester burst hold; meaningful only while granted
- wr_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- wr_data  in  NREQ*WIDTH  flattened data; requester i at [i*WIDTH +: WIDTH]
- grant  out  NREQ  registered one-hot grant; all-zero when idle
- busy  out  1  high while in WRITE state
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  combinational read of bank[rd_addr]

## Operation
- Two-state FSM:
  - IDLE: grant=0 and busy=0. If any req bit is set, the winner is the first requester with req set, searching from ptr upward and wrapping modulo NREQ. Next state is WRITE, grant <= onehot(winner), burst_cnt <= 0.
  - IDLE with no request: stays in IDLE.
- WRITE: grant and busy are high. At the closing clock edge, bank[wr_addr[w]] <= wr_data[w], using the values present during this cycle.
- WRITE exit:
  - If req[w] && lock[w] && burst_cnt < BURST_MAX-1: stay in WRITE, same grant, burst_cnt++.
  - Otherwise: next state is IDLE, grant <= 0, ptr <= (w+1) mod NREQ.
- Requester rules:
  - A requester holds req, wr_addr and wr_data stable until it sees its grant bit.
  - Dropping req in the same cycle the grant is high does not cancel that cycle's write.
- Address rules:
  - wr_addr ≥ NREG: the grant cycle is consumed and no register changes.
  - rd_addr ≥ NREG: rd_data = 0.
- Read during write: a read of the address being written returns the old value during the grant cycle and the new value from the next cycle on. There is no bypass.
- lock on a requester that is not granted is ignored.
- Reset, including mid-burst, clears:
  - every bank word to 0
  - state to IDLE, with grant=0 and busy=0
  - ptr to 0 and burst_cnt to 0

## Timing
- Request-to-grant latency: req sampled high in IDLE at cycle k gives grant high in cycle k+1, and the bank is updated at the end of k+1.
- Unlocked write occupancy: 2 cycles (IDLE bubble + WRITE). Maximum unlocked throughput is one write every 2 cycles.
- Locked burst: up to BURST_MAX back-to-back write cycles, then a forced return to IDLE. Any requester is then served within NREQ*(BURST_MAX+1) cycles of asserting req.
- rd_data is valid in the same cycle as rd_addr (combinational).
- Output values during and after reset: grant=0, busy=0, rd_data=0 for all addresses from the cycle after reset is sampled.

## Structure
- Shared package reg_arb_pkg contains:
  - state encoding localparams: ST_IDLE=1'b0, ST_WRITE=1'b1
  - a clog2 function used for AW and the burst_cnt width
- Sub-module register_ce(q, d, ce, clk, reset): an n-bit register with synchronous active-high reset to 0 and a clock enable.
  - The bank is a generate loop of NREG instances.
  - The enable for word j is (state==WRITE) && (wr_addr[w]==j).
- Arbitration logic (rotate, priority-pick, one-hot) and the FSM live in the top module.

## Test plan
- Reset, then read all addresses → rd_data=0 everywhere; grant=0, busy=0.
- Single write: req[2]=1, addr=5, data=8'hA5 at cycle 1 → grant=4'b0100 in cycle 2; bank[5]=8'hA5 from cycle 3; ptr=3.
- Fairness: req=4'b1111 held with distinct addr/data per requester → grants in order 0,1,2,3,0 on every other cycle; each requester's data lands at its address.
- Lock burst with BURST_MAX=4: req[1]=lock[1]=1 for 10 cycles, addresses 0..7 → 4 consecutive grant=4'b0010 cycles, 1 IDLE cycle, then regrant. A competing req[3] is granted immediately after the first burst ends.
- Out-of-range write: NREG=6, req[0] with addr=7 → grant asserted for one cycle; all words unchanged; rd_addr=7 gives 0.
- Reset asserted in the 2nd cycle of a locked burst → next cycle grant=0, busy=0, bank all 0; after release, req=4'b1000 is granted first.
